cliffwalk_env_scheduler: RTL

Multi-environment front end for the single-step CliffWalking compute stage (`Compute_Single`). It holds the per-environment grid state and step count for `NUM_ENV` environments. It accepts one packed action vector per batch and issues one (state, action) pair per cycle to the compute stage. It then writes back the next state, streams per-environment results to the agent side, and auto-resets environments that finish or time out.

---
 rtl/cliffwalk_pkg.sv | 23 ++
 rtl/cliffwalk_env_scheduler_tag_pipe.sv | 35 +++
 rtl/cliffwalk_env_scheduler.sv | 110 +++++++++++
 3 files changed

// File: rtl/cliffwalk_pkg.sv
// cliffwalk_pkg: CliffWalking grid constants, action codes, scheduler FSM encodings and default widths
package cliffwalk_pkg;
  localparam int ROWS = 4;
  localparam int COLS = 12;
  localparam int START_CELL = 36;
  localparam int GOAL_CELL = 47;
  localparam int CLIFF_LO = 37;
  localparam int CLIFF_HI = 46;
  localparam logic [1:0] ACT_UP = 2'd0;
  localparam logic [1:0] ACT_RIGHT = 2'd1;
  localparam logic [1:0] ACT_DOWN = 2'd2;
  localparam logic [1:0] ACT_LEFT = 2'd3;
  localparam logic [1:0] ST_IDLE = 2'd0;
  localparam logic [1:0] ST_ISSUE = 2'd1;
  localparam logic [1:0] ST_DRAIN = 2'd2;
  localparam int DEF_NUM_ENV = 32;
  localparam int DEF_ENV_W = 5;
  localparam int DEF_STA_W = 32;
  localparam int DEF_RWD_W = 32;
  localparam int DEF_CMP_LAT = 1;
  localparam int DEF_MAX_STEPS = 100;
  localparam int DEF_CNT_W = 16;
endpackage

// File: rtl/cliffwalk_env_scheduler_tag_pipe.sv
// cliffwalk_tag_pipe: DEPTH-stage shift register of {valid, env id} tracking in-flight compute requests
// Ports: clk/rst (sync clear), push/push_env enter stage 0, pop_valid/pop_env leave the last stage,
// busy is high while any stage holds a valid tag.
module cliffwalk_tag_pipe #(
  parameter int DEPTH = 1,
  parameter int ENV_W = 5
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             push,
  input  logic [ENV_W-1:0] push_env,
  output logic             pop_valid,
  output logic [ENV_W-1:0] pop_env,
  output logic             busy
);
  logic [DEPTH-1:0] vld;
  logic [DEPTH*ENV_W-1:0] env_q;
  logic [DEPTH:0] vld_chain;
  logic [(DEPTH+1)*ENV_W-1:0] env_chain;
  // Appending the new tag below the current stages and dropping the top makes DEPTH=1 work without special cases.
  assign vld_chain = {vld, push};
  assign env_chain = {env_q, push_env};
  always_ff @(posedge clk) begin
    if (rst) begin
      vld <= '0;
      env_q <= '0;
    end else begin
      vld <= vld_chain[DEPTH-1:0];
      env_q <= env_chain[DEPTH*ENV_W-1:0];
    end
  end
  assign pop_valid = vld[DEPTH-1];
  assign pop_env = env_q[DEPTH*ENV_W-1 -: ENV_W];
  assign busy = |vld;
endmodule

// File: rtl/cliffwalk_env_scheduler.sv
// cliffwalk_env_scheduler: runs NUM_ENV CliffWalking environments through one single-step compute stage
// Ports: i_act_valid/i_act_data/o_act_ready accept one packed action batch (2 bits per env) when idle;
// o_cmp_ena/o_cmp_sta/o_cmp_act issue one env per cycle and i_cmp_* return its result CMP_LAT cycles later;
// o_res_* stream one registered beat per env; o_err is a sticky tag/valid mismatch flag.
module cliffwalk_env_scheduler
  import cliffwalk_pkg::*;
#(
  parameter int NUM_ENV = DEF_NUM_ENV,
  parameter int ENV_W = DEF_ENV_W,
  parameter int STA_W = DEF_STA_W,
  parameter int RWD_W = DEF_RWD_W,
  parameter int CMP_LAT = DEF_CMP_LAT,
  parameter int MAX_STEPS = DEF_MAX_STEPS,
  parameter int CNT_W = DEF_CNT_W,
  parameter int START_STA = START_CELL
) (
  input  logic                 i_clk,
  input  logic                 i_rst,
  input  logic                 i_act_valid,
  input  logic [2*NUM_ENV-1:0] i_act_data,
  output logic                 o_act_ready,
  output logic                 o_cmp_ena,
  output logic [STA_W-1:0]     o_cmp_sta,
  output logic [1:0]           o_cmp_act,
  input  logic [STA_W-1:0]     i_cmp_sta,
  input  logic [STA_W-1:0]     i_cmp_obs,
  input  logic [RWD_W-1:0]     i_cmp_rwd,
  input  logic                 i_cmp_done,
  input  logic                 i_cmp_valid,
  output logic                 o_res_valid,
  output logic [ENV_W-1:0]     o_res_env,
  output logic [STA_W-1:0]     o_res_obs,
  output logic [RWD_W-1:0]     o_res_rwd,
  output logic                 o_res_done,
  output logic                 o_res_trunc,
  output logic                 o_err
);
  localparam logic [ENV_W-1:0] LAST_ENV = ENV_W'(NUM_ENV - 1);
  logic [1:0] fsm;
  logic [ENV_W-1:0] k;
  logic [2*NUM_ENV-1:0] act_buf;
  logic [STA_W-1:0] sta_q [NUM_ENV];
  logic [CNT_W-1:0] cnt_q [NUM_ENV];
  logic issuing, pop_valid, busy, hit, trunc, restart;
  logic [ENV_W-1:0] pop_env;
  logic [CNT_W-1:0] cnt_nx;
  assign issuing = fsm == ST_ISSUE;
  assign o_act_ready = fsm == ST_IDLE;
  assign o_cmp_ena = issuing;
  assign o_cmp_sta = issuing ? sta_q[k] : '0;
  assign o_cmp_act = issuing ? act_buf[2*k +: 2] : 2'd0;
  cliffwalk_tag_pipe #(.DEPTH(CMP_LAT), .ENV_W(ENV_W)) u_tag_pipe (
    .clk(i_clk),
    .rst(i_rst),
    .push(issuing),
    .push_env(k),
    .pop_valid(pop_valid),
    .pop_env(pop_env),
    .busy(busy)
  );
  // Result data is trusted only when the expected tag and the compute valid line up.
  assign hit = pop_valid & i_cmp_valid;
  assign cnt_nx = cnt_q[pop_env] + CNT_W'(1);
  assign trunc = !i_cmp_done && (cnt_nx >= CNT_W'(MAX_STEPS));
  assign restart = i_cmp_done || trunc;
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      fsm <= ST_IDLE;
      k <= '0;
      act_buf <= '0;
    end else if (fsm == ST_IDLE && i_act_valid) begin
      fsm <= ST_ISSUE;
      k <= '0;
      act_buf <= i_act_data;
    end else if (issuing) begin
      k <= k + ENV_W'(1);
      fsm <= (k == LAST_ENV) ? ST_DRAIN : ST_ISSUE;
    end else if (fsm == ST_DRAIN && !busy) begin
      fsm <= ST_IDLE;
    end
  end
  // No read/write bypass: an env is issued once per batch, so its write-back never races its own read.
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      for (int i = 0; i < NUM_ENV; i++) begin
        sta_q[i] <= STA_W'(START_STA);
        cnt_q[i] <= '0;
      end
      o_res_valid <= 1'b0;
      o_res_env <= '0;
      o_res_obs <= '0;
      o_res_rwd <= '0;
      o_res_done <= 1'b0;
      o_res_trunc <= 1'b0;
      o_err <= 1'b0;
    end else begin
      o_res_valid <= hit;
      if (hit) begin
        o_res_env <= pop_env;
        o_res_obs <= i_cmp_obs;
        o_res_rwd <= i_cmp_rwd;
        o_res_done <= i_cmp_done;
        o_res_trunc <= trunc;
        sta_q[pop_env] <= restart ? STA_W'(START_STA) : i_cmp_sta;
        cnt_q[pop_env] <= restart ? '0 : cnt_nx;
      end
      if (pop_valid != i_cmp_valid) o_err <= 1'b1;
    end
  end
endmodule
